// File: rtl/contador_ud_param_if.sv
// rtl/contador_ud_param_if.sv - control and status bundle for the up/down counter
// master drives load/count controls, slave is the counter.
interface contador_ud_param_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             pl_n;
  logic [WIDTH-1:0] p;
  logic             ce;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tcu;
  logic             tcd;
  logic             ovf;
  logic             lderr;

  modport master (
    output clr, pl_n, p, ce, up,
    input  q, tcu, tcd, ovf, lderr
  );

  modport slave (
    input  clr, pl_n, p, ce, up,
    output q, tcu, tcd, ovf, lderr
  );
endinterface

// File: rtl/contador_ud_param.sv
// rtl/contador_ud_param.sv - parametrised up/down counter with modulus, load, saturate and cascade
// Priority per edge: clear > load > count > hold; terminal counts are combinational for rippling.
module contador_ud_param #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 2 ** WIDTH,
  parameter bit SATURA = 1'b0
) (
  input  logic              cp,
  input  logic              mr_n,
  contador_ud_param_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] q_r;
  logic             ovf_r;
  logic             lderr_r;

  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      q_r     <= '0;
      ovf_r   <= 1'b0;
      lderr_r <= 1'b0;
    end else if (bus.clr) begin
      q_r     <= '0;
      ovf_r   <= 1'b0;
      lderr_r <= 1'b0;
    end else if (!bus.pl_n) begin
      // Out-of-range loads clamp to the top of the range and leave a sticky mark.
      if (bus.p > MAXV) begin
        q_r     <= MAXV;
        lderr_r <= 1'b1;
      end else begin
        q_r <= bus.p;
      end
    end else if (bus.ce) begin
      if (bus.up) begin
        if (q_r == MAXV) begin
          ovf_r <= 1'b1;
          if (!SATURA) q_r <= '0;
        end else begin
          q_r <= q_r + WIDTH'(1);
        end
      end else begin
        if (q_r == '0) begin
          ovf_r <= 1'b1;
          if (!SATURA) q_r <= MAXV;
        end else begin
          q_r <= q_r - WIDTH'(1);
        end
      end
    end
  end

  assign bus.q     = q_r;
  assign bus.ovf   = ovf_r;
  assign bus.lderr = lderr_r;
  assign bus.tcu   = bus.ce &  bus.up & (q_r == MAXV);
  assign bus.tcd   = bus.ce & ~bus.up & (q_r == '0);

endmodule

// File: tb/tb_contador_ud_param.sv
// tb/tb_contador_ud_param.sv - directed self-checking bench for contador_ud_param
// Wrap, saturate and modulo-16 instances share one control set; two instances form a cascade.
module tb_contador_ud_param;

  logic cp = 1'b0;
  logic mr_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 cp = ~cp;

  contador_ud_param_if #(.WIDTH(4)) a ();
  contador_ud_param_if #(.WIDTH(4)) s ();
  contador_ud_param_if #(.WIDTH(4)) f ();
  contador_ud_param_if #(.WIDTH(4)) lo ();
  contador_ud_param_if #(.WIDTH(4)) hi ();

  assign s.clr = a.clr;  assign s.pl_n = a.pl_n;  assign s.p = a.p;
  assign s.ce  = a.ce;   assign s.up   = a.up;
  assign f.clr = a.clr;  assign f.pl_n = a.pl_n;  assign f.p = a.p;
  assign f.ce  = a.ce;   assign f.up   = a.up;
  assign hi.clr = lo.clr; assign hi.pl_n = lo.pl_n; assign hi.p = lo.p;
  assign hi.up  = lo.up;  assign hi.ce   = lo.tcu | lo.tcd;

  contador_ud_param #(.WIDTH(4), .MODULO(10), .SATURA(1'b0)) dut_wrap (.cp(cp), .mr_n(mr_n), .bus(a));
  contador_ud_param #(.WIDTH(4), .MODULO(10), .SATURA(1'b1)) dut_sat  (.cp(cp), .mr_n(mr_n), .bus(s));
  contador_ud_param #(.WIDTH(4))                             dut_m16  (.cp(cp), .mr_n(mr_n), .bus(f));
  contador_ud_param #(.WIDTH(4), .MODULO(10), .SATURA(1'b0)) dut_lo   (.cp(cp), .mr_n(mr_n), .bus(lo));
  contador_ud_param #(.WIDTH(4), .MODULO(10), .SATURA(1'b0)) dut_hi   (.cp(cp), .mr_n(mr_n), .bus(hi));

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  task automatic ctrl(input logic clr, input logic pl_n, input logic [3:0] p, input logic ce, input logic up);
    a.clr = clr; a.pl_n = pl_n; a.p = p; a.ce = ce; a.up = up;
  endtask

  task automatic test_reset();
    ctrl(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    lo.clr = 1'b0; lo.pl_n = 1'b1; lo.p = 4'd0; lo.ce = 1'b0; lo.up = 1'b1;
    step();
    checks++; if (a.q !== 4'd0 || a.ovf !== 1'b0 || a.lderr !== 1'b0) begin failures++; $display("FAIL reset_init q=%0d ovf=%b lderr=%b exp 0/0/0", a.q, a.ovf, a.lderr); end
    mr_n = 1'b1;
    ctrl(1'b0, 1'b0, 4'd7, 1'b0, 1'b1);
    step();
    checks++; if (a.q !== 4'd7) begin failures++; $display("FAIL load7 q=%0d exp=7", a.q); end
    ctrl(1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    #2 mr_n = 1'b0;
    #1;
    checks++; if (a.q !== 4'd0 || a.ovf !== 1'b0 || a.lderr !== 1'b0) begin failures++; $display("FAIL async_reset q=%0d ovf=%b lderr=%b exp 0/0/0", a.q, a.ovf, a.lderr); end
    mr_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (a.q !== 4'd3) begin failures++; $display("FAIL count_after_reset q=%0d exp=3", a.q); end
  endtask

  task automatic test_up_wrap_sat();
    ctrl(1'b0, 1'b0, 4'd8, 1'b0, 1'b1);
    step();
    checks++; if (a.q !== 4'd8 || s.q !== 4'd8) begin failures++; $display("FAIL load8 wrap=%0d sat=%0d exp=8", a.q, s.q); end
    ctrl(1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    #1;
    checks++; if (a.tcu !== 1'b0) begin failures++; $display("FAIL tcu_at8 tcu=%b exp=0", a.tcu); end
    step();
    checks++; if (a.q !== 4'd9 || a.tcu !== 1'b1 || a.tcd !== 1'b0) begin failures++; $display("FAIL at9 q=%0d tcu=%b tcd=%b exp 9/1/0", a.q, a.tcu, a.tcd); end
    step();
    checks++; if (a.q !== 4'd0 || a.ovf !== 1'b1) begin failures++; $display("FAIL wrap_up q=%0d ovf=%b exp 0/1", a.q, a.ovf); end
    checks++; if (s.q !== 4'd9 || s.ovf !== 1'b1) begin failures++; $display("FAIL sat_up q=%0d ovf=%b exp 9/1", s.q, s.ovf); end
    checks++; if (f.q !== 4'd10 || f.ovf !== 1'b0) begin failures++; $display("FAIL m16_past9 q=%0d ovf=%b exp 10/0", f.q, f.ovf); end
  endtask

  task automatic test_down_clr();
    ctrl(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    step();
    ctrl(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    #1;
    checks++; if (a.tcd !== 1'b1 || a.tcu !== 1'b0) begin failures++; $display("FAIL tcd_at0 tcd=%b tcu=%b exp 1/0", a.tcd, a.tcu); end
    step();
    checks++; if (a.q !== 4'd9 || a.ovf !== 1'b1) begin failures++; $display("FAIL wrap_down q=%0d ovf=%b exp 9/1", a.q, a.ovf); end
    checks++; if (s.q !== 4'd0 || s.ovf !== 1'b1) begin failures++; $display("FAIL sat_down q=%0d ovf=%b exp 0/1", s.q, s.ovf); end
    ctrl(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    step();
    checks++; if (a.q !== 4'd0 || a.ovf !== 1'b0) begin failures++; $display("FAIL clr q=%0d ovf=%b exp 0/0", a.q, a.ovf); end
  endtask

  task automatic test_load_range();
    ctrl(1'b0, 1'b0, 4'd12, 1'b0, 1'b1);
    step();
    checks++; if (a.q !== 4'd9 || a.lderr !== 1'b1 || a.ovf !== 1'b0) begin failures++; $display("FAIL load12 q=%0d lderr=%b ovf=%b exp 9/1/0", a.q, a.lderr, a.ovf); end
    checks++; if (f.q !== 4'd12 || f.lderr !== 1'b0) begin failures++; $display("FAIL m16_load12 q=%0d lderr=%b exp 12/0", f.q, f.lderr); end
    ctrl(1'b0, 1'b0, 4'd4, 1'b0, 1'b1);
    step();
    checks++; if (a.q !== 4'd4 || a.lderr !== 1'b1) begin failures++; $display("FAIL load4 q=%0d lderr=%b exp 4/1", a.q, a.lderr); end
    ctrl(1'b0, 1'b0, 4'd15, 1'b0, 1'b1);
    step();
    ctrl(1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    #1;
    checks++; if (f.tcu !== 1'b1) begin failures++; $display("FAIL m16_tcu tcu=%b exp=1", f.tcu); end
    step();
    checks++; if (f.q !== 4'd0 || f.ovf !== 1'b1) begin failures++; $display("FAIL m16_wrap q=%0d ovf=%b exp 0/1", f.q, f.ovf); end
    checks++; if (a.q !== 4'd0 || a.ovf !== 1'b1 || a.lderr !== 1'b1) begin failures++; $display("FAIL clamp_wrap q=%0d ovf=%b lderr=%b exp 0/1/1", a.q, a.ovf, a.lderr); end
  endtask

  task automatic test_priority();
    ctrl(1'b1, 1'b0, 4'd5, 1'b1, 1'b1);
    step();
    checks++; if (a.q !== 4'd0 || a.lderr !== 1'b0 || a.ovf !== 1'b0) begin failures++; $display("FAIL clr_over_load q=%0d lderr=%b ovf=%b exp 0/0/0", a.q, a.lderr, a.ovf); end
    ctrl(1'b0, 1'b0, 4'd5, 1'b1, 1'b1);
    step();
    checks++; if (a.q !== 4'd5) begin failures++; $display("FAIL load_over_ce q=%0d exp=5", a.q); end
    ctrl(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    step();
    step();
    checks++; if (a.q !== 4'd5 || a.ovf !== 1'b0) begin failures++; $display("FAIL hold q=%0d ovf=%b exp 5/0", a.q, a.ovf); end
  endtask

  task automatic test_cascade();
    lo.clr = 1'b1; lo.ce = 1'b0;
    step();
    lo.clr = 1'b0; lo.ce = 1'b1; lo.up = 1'b1;
    for (int i = 0; i < 25; i++) step();
    checks++; if (hi.q !== 4'd2 || lo.q !== 4'd5) begin failures++; $display("FAIL cascade_up hi=%0d lo=%0d exp 2/5", hi.q, lo.q); end
    lo.up = 1'b0;
    for (int i = 0; i < 26; i++) step();
    checks++; if (hi.q !== 4'd9 || lo.q !== 4'd9) begin failures++; $display("FAIL cascade_down hi=%0d lo=%0d exp 9/9", hi.q, lo.q); end
  endtask

  initial begin
    test_reset();
    test_up_wrap_sat();
    test_down_clr();
    test_load_range();
    test_priority();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
